// File: rtl/gray_pkg.sv
// gray_pkg: shared definitions for the grayscale converter and its reuse in
// the halftone error-diffusion path.
//   rnd_mode_e : rounding-mode encodings
//   sum_w()    : width of the lossless R*cr + G*cg + B*cb accumulator
package gray_pkg;

   typedef enum logic [1:0] {
      RND_CEIL    = 2'b00,
      RND_TRUNC   = 2'b01,
      RND_EVEN    = 2'b10,
      RND_HALF_UP = 2'b11
   } rnd_mode_e;

   // Three products of CW x (FRAC+1) bits summed: CW+FRAC+1 bits each, +2 for the adds.
   function automatic int sum_w(input int cw, input int frac);
      return cw + frac + 3;
   endfunction

endpackage

// File: rtl/gray_round_sat.sv
// gray_round_sat: combinational rounding and saturation of a fixed-point
// weighted sum down to a CW-bit gray value.
//   sum  in  sum_w(CW,FRAC)  unsigned sum, FRAC fraction bits
//   mode in  2               rounding mode (rnd_mode_e)
//   gray out CW              rounded value, clamped to 2^CW-1
module gray_round_sat
   import gray_pkg::*;
#(
   parameter int CW   = 8,
   parameter int FRAC = 4
) (
   input  logic [sum_w(CW, FRAC)-1:0] sum,
   input  logic [1:0]                 mode,
   output logic [CW-1:0]              gray
);

   localparam int SW = sum_w(CW, FRAC);
   localparam int IW = SW - FRAC;
   localparam logic [FRAC-1:0] HALF = FRAC'(1) << (FRAC - 1);
   localparam logic [IW:0]     ONE  = (IW + 1)'(1);
   localparam logic [IW:0]     MAXV = (IW + 1)'((1 << CW) - 1);

   logic [IW-1:0]   ipart;
   logic [FRAC-1:0] f;
   logic            up;
   logic [IW:0]     rnd;

   assign ipart = sum[SW-1:FRAC];
   assign f     = sum[FRAC-1:0];

   always_comb begin
      up = 1'b0;
      case (mode)
         RND_CEIL:  up = (f != '0);
         RND_TRUNC: up = 1'b0;
         // ties go to the even integer
         RND_EVEN:  up = (f > HALF) || ((f == HALF) && ipart[0]);
         default:   up = (f >= HALF);
      endcase
   end

   // one extra bit so ceiling of an all-ones integer part cannot wrap
   assign rnd  = {1'b0, ipart} + (up ? ONE : '0);
   assign gray = (rnd > MAXV) ? {CW{1'b1}} : rnd[CW-1:0];

endmodule

// File: rtl/gray_convert_pipe.sv
// gray_convert_pipe: two-stage RGB-to-gray converter with programmable
// weights, four rounding modes, saturation, valid/ready flow control and
// per-frame pixel counting.
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready/in_pix/in_last   pixel input ({B,G,R})
//   cfg_we/cfg_mode/cfg_coef_*      settings load
//   out_valid/out_ready/out_gray/out_last  gray output
//   frame_done                      high during the handshake of the last pixel
//   pix_cnt                         output handshakes so far in this frame
module gray_convert_pipe
   import gray_pkg::*;
#(
   parameter int CW         = 8,
   parameter int FRAC       = 4,
   parameter int COEF_R_RST = 5,
   parameter int COEF_G_RST = 9,
   parameter int COEF_B_RST = 2,
   parameter int CNT_W      = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3*CW-1:0]   in_pix,
   input  logic              in_last,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_mode,
   input  logic [FRAC:0]     cfg_coef_r,
   input  logic [FRAC:0]     cfg_coef_g,
   input  logic [FRAC:0]     cfg_coef_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CW-1:0]     out_gray,
   output logic              out_last,
   output logic              frame_done,
   output logic [CNT_W-1:0]  pix_cnt
);

   localparam int SW     = sum_w(CW, FRAC);
   localparam int STAGES = 2;

   // ---------------- settings ----------------
   logic [1:0]  mode_q;
   logic [FRAC:0] cr_q, cg_q, cb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= RND_TRUNC;
         cr_q   <= (FRAC + 1)'(COEF_R_RST);
         cg_q   <= (FRAC + 1)'(COEF_G_RST);
         cb_q   <= (FRAC + 1)'(COEF_B_RST);
      end else if (cfg_we) begin
         mode_q <= cfg_mode;
         cr_q   <= cfg_coef_r;
         cg_q   <= cfg_coef_g;
         cb_q   <= cfg_coef_b;
      end
   end

   // ---------------- flow control ----------------
   logic [STAGES:1] vld_pipe;
   logic            s1_adv, s2_adv, out_hs;

   assign s2_adv   = !vld_pipe[2] || out_ready;
   assign s1_adv   = !vld_pipe[1] || s2_adv;
   assign in_ready = s1_adv;
   assign out_hs   = vld_pipe[2] && out_ready;

   // ---------------- stage 1: MAC ----------------
   // The sum is formed from the live settings, so a pixel is bound to the
   // settings in force at the edge that accepts it.
   logic [SW-1:0] mac, s1_sum;
   logic [1:0]    s1_mode;
   logic          s1_last;

   assign mac = SW'(in_pix[CW-1:0])      * SW'(cr_q)
              + SW'(in_pix[2*CW-1:CW])   * SW'(cg_q)
              + SW'(in_pix[3*CW-1:2*CW]) * SW'(cb_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe[1] <= 1'b0;
         s1_sum      <= '0;
         s1_mode     <= RND_TRUNC;
         s1_last     <= 1'b0;
      end else if (s1_adv) begin
         vld_pipe[1] <= in_valid;
         if (in_valid) begin
            s1_sum  <= mac;
            s1_mode <= mode_q;
            s1_last <= in_last;
         end
      end
   end

   // ---------------- stage 2: round / saturate ----------------
   logic [CW-1:0] rnd_gray;

   gray_round_sat #(.CW(CW), .FRAC(FRAC)) u_rnd (
      .sum  (s1_sum),
      .mode (s1_mode),
      .gray (rnd_gray)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe[2] <= 1'b0;
         out_gray    <= '0;
         out_last    <= 1'b0;
      end else if (s2_adv) begin
         vld_pipe[2] <= vld_pipe[1];
         if (vld_pipe[1]) begin
            out_gray <= rnd_gray;
            out_last <= s1_last;
         end
      end
   end

   assign out_valid = vld_pipe[2];

   // ---------------- frame tracking ----------------
   assign frame_done = out_hs && out_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pix_cnt <= '0;
      else if (out_hs)
         pix_cnt <= out_last ? '0 : pix_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_gray_convert_pipe.sv
module tb_gray_convert_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] in_pix = '0;
   logic        in_last = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_mode = 2'b01;
   logic [4:0]  cfg_coef_r = 5'd5, cfg_coef_g = 5'd9, cfg_coef_b = 5'd2;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_gray;
   logic        out_last;
   logic        frame_done;
   logic [23:0] pix_cnt;

   gray_convert_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix), .in_last(in_last),
      .cfg_we(cfg_we), .cfg_mode(cfg_mode),
      .cfg_coef_r(cfg_coef_r), .cfg_coef_g(cfg_coef_g), .cfg_coef_b(cfg_coef_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_gray(out_gray),
      .out_last(out_last), .frame_done(frame_done), .pix_cnt(pix_cnt)
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] g; logic l; } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_bad = 0;
   int mcnt  = 0;
   bit stop_rnd = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // scoreboard monitor: outputs sampled mid-cycle, ahead of the edge that completes the handshake
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_output: got gray %0d with empty scoreboard", out_gray);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("gray", out_gray, e.g);
               chk("out_last", out_last, e.l);
               chk("frame_done", frame_done, e.l);
               chk("pix_cnt", pix_cnt, mcnt);
               mcnt = e.l ? 0 : mcnt + 1;
            end
         end else begin
            chk("frame_done_idle", frame_done, 0);
         end
      end
   end

   task automatic send(input logic [23:0] p, input logic l, input logic [7:0] e);
      int n = 0;
      exp_t x;
      x.g = e; x.l = l;
      sb.push_back(x);
      in_valid = 1'b1; in_pix = p; in_last = l;
      @(negedge clk);
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      if (!in_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: in_ready stayed %0d, required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic cfg(input logic [1:0] m, input logic [4:0] r, input logic [4:0] g, input logic [4:0] b);
      cfg_we = 1'b1; cfg_mode = m; cfg_coef_r = r; cfg_coef_g = g; cfg_coef_b = b;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
      chk("drain_left", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   logic [7:0] rnd_exp [4] = '{8'd254, 8'd253, 8'd253, 8'd253};
   logic [7:0] tie_exp [4] = '{8'd1, 8'd0, 8'd0, 8'd1};

   initial begin
      // ---- reset state ----
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_gray", out_gray, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_pix_cnt", pix_cnt, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // ---- rounding of 4053/16 = 253 + 5/16 ----
      for (int m = 0; m < 4; m++) begin
         cfg(m[1:0], 5'd5, 5'd9, 5'd2);
         send(24'hFFFCFF, 1'b0, rnd_exp[m]);
      end

      // ---- exact half ties: 0.5 and 1.5 ----
      for (int m = 0; m < 4; m++) begin
         cfg(m[1:0], 5'd5, 5'd9, 5'd2);
         send(24'h040000, 1'b0, tie_exp[m]);
      end
      cfg(2'b10, 5'd5, 5'd9, 5'd2);
      send(24'h0C0000, 1'b0, 8'd2);
      cfg(2'b01, 5'd5, 5'd9, 5'd2);
      send(24'h0C0000, 1'b0, 8'd1);

      // ---- settings write alongside an input transfer: old mode applies ----
      fork
         send(24'h040000, 1'b0, 8'd0);
         begin
            cfg_we = 1'b1; cfg_mode = 2'b00;
            @(posedge clk); #1;
            cfg_we = 1'b0;
         end
      join
      send(24'h040000, 1'b0, 8'd1);

      // ---- saturation ----
      for (int m = 0; m < 4; m++) begin
         cfg(m[1:0], 5'd16, 5'd16, 5'd16);
         send(24'hFFFFFF, 1'b0, 8'hFF);
      end
      cfg(2'b01, 5'd16, 5'd16, 5'd16);
      send(24'h101010, 1'b0, 8'h30);
      drain();

      // ---- backpressure ----
      cfg(2'b01, 5'd5, 5'd9, 5'd2);
      out_ready = 1'b0;
      fork
         begin
            send(24'h101010, 1'b0, 8'd16);
            send(24'h000020, 1'b0, 8'd10);
            send(24'h002000, 1'b0, 8'd18);
            send(24'h400000, 1'b0, 8'd8);
         end
         begin
            repeat (2) @(posedge clk);
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("bp_in_ready", in_ready, 0);
               chk("bp_out_valid", out_valid, 1);
               chk("bp_hold_gray", out_gray, 16);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // ---- reset mid-stream ----
      cfg(2'b00, 5'd16, 5'd16, 5'd16);
      out_ready = 1'b0;
      send(24'h010101, 1'b0, 8'd3);
      send(24'h020202, 1'b0, 8'd6);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_pix_cnt", pix_cnt, 0);
      chk("mrst_out_gray", out_gray, 0);
      sb.delete();
      mcnt = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("mrst_no_stale", out_valid, 0);
      end
      @(posedge clk); #1;
      // reset settings: 5/9/2 truncate
      send(24'hFFFCFF, 1'b0, 8'd253);
      drain();

      // ---- frame of 5 with random out_ready ----
      stop_rnd = 0;
      fork
         begin
            while (!stop_rnd) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
         begin
            for (int k = 1; k <= 5; k++)
               send(24'(16 * k), (k == 5), 8'(5 * k));
            drain();
            stop_rnd = 1;
         end
      join
      @(negedge clk);
      chk("frame_cnt_zero", pix_cnt, 0);
      chk("frame_model_cnt", mcnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1);
   end

endmodule
